// File: rtl/decode_stage_p_if.sv
// Fetch, writeback, control and ID/EX output bundle for decode_stage_p.
// master drives instructions, writebacks and out_ready; slave is the decode stage.
interface decode_stage_p_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RA_W   = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic [RA_W-1:0]   in_src_a;
    logic [RA_W-1:0]   in_src_b;
    logic              in_use_a;
    logic              in_use_b;
    logic [RA_W-1:0]   in_dest;
    logic              in_wr;

    logic              wb_load;
    logic [RA_W-1:0]   wb_dest;
    logic [DATA_W-1:0] wb_data;

    logic              flush;
    logic              sb_clear;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [RA_W-1:0]   out_dest;
    logic              out_wr;

    logic              stall_raw;

    modport master (
        output in_valid, in_instr, in_src_a, in_src_b, in_use_a, in_use_b, in_dest, in_wr,
        output wb_load, wb_dest, wb_data, flush, sb_clear, out_ready,
        input  in_ready, out_valid, out_instr, out_a, out_b, out_dest, out_wr, stall_raw
    );

    modport slave (
        input  in_valid, in_instr, in_src_a, in_src_b, in_use_a, in_use_b, in_dest, in_wr,
        input  wb_load, wb_dest, wb_data, flush, sb_clear, out_ready,
        output in_ready, out_valid, out_instr, out_a, out_b, out_dest, out_wr, stall_raw
    );
endinterface

// File: rtl/decode_stage_p.sv
// Decode stage: register file with writeback bypass, per-register pending-write
// counters for RAW/WAW-overflow stalls, and a registered ID/EX output slot.
module decode_stage_p #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned RA_W   = 3,
    parameter int unsigned CNT_W  = 2
) (
    input logic             clk,
    input logic             reset_n,
    decode_stage_p_if.slave bus
);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [DATA_W-1:0] rf_q  [NREGS];
    logic [CNT_W-1:0]  cnt_q [NREGS];
    logic [CNT_W-1:0]  cnt_d [NREGS];

    logic [DATA_W-1:0] rd_a, rd_b;
    logic              wb_hit_a, wb_hit_b;
    logic              bypass_a, bypass_b;
    logic              busy_a, busy_b, dest_full;
    logic              hazard, in_ready, accept, squash;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_instr_q, out_instr_d;
    logic [DATA_W-1:0] out_a_q, out_a_d;
    logic [DATA_W-1:0] out_b_q, out_b_d;
    logic [RA_W-1:0]   out_dest_q, out_dest_d;
    logic              out_wr_q, out_wr_d;

    // Operand reads see a same-cycle writeback; a source may issue early only if
    // that writeback retires its last outstanding write.
    always_comb begin
        wb_hit_a  = bus.wb_load && (bus.wb_dest == bus.in_src_a);
        wb_hit_b  = bus.wb_load && (bus.wb_dest == bus.in_src_b);
        rd_a      = wb_hit_a ? bus.wb_data : rf_q[bus.in_src_a];
        rd_b      = wb_hit_b ? bus.wb_data : rf_q[bus.in_src_b];
        bypass_a  = wb_hit_a && (cnt_q[bus.in_src_a] == CntOne);
        bypass_b  = wb_hit_b && (cnt_q[bus.in_src_b] == CntOne);
        busy_a    = bus.in_use_a && (cnt_q[bus.in_src_a] != '0) && !bypass_a;
        busy_b    = bus.in_use_b && (cnt_q[bus.in_src_b] != '0) && !bypass_b;
        dest_full = bus.in_wr && (cnt_q[bus.in_dest] == CntMax);
        hazard    = bus.in_valid && (busy_a || busy_b || dest_full);
        in_ready  = !hazard && (!out_valid_q || bus.out_ready) && !bus.flush;
        accept    = bus.in_valid && in_ready;
        squash    = bus.flush && out_valid_q && out_wr_q;
    end

    assign bus.in_ready  = in_ready;
    assign bus.stall_raw = hazard;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_dest  = out_dest_q;
    assign bus.out_wr    = out_wr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (bus.wb_load) begin
            rf_q[bus.wb_dest] <= bus.wb_data;
        end
    end

    // Increment, then writeback retire, then squash retire; decrements saturate at 0.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (accept && bus.in_wr && (bus.in_dest == RA_W'(r))) begin
                cnt_d[r] = cnt_d[r] + CntOne;
            end
            if (bus.wb_load && (bus.wb_dest == RA_W'(r)) && (cnt_d[r] != '0)) begin
                cnt_d[r] = cnt_d[r] - CntOne;
            end
            if (squash && (out_dest_q == RA_W'(r)) && (cnt_d[r] != '0)) begin
                cnt_d[r] = cnt_d[r] - CntOne;
            end
            if (bus.sb_clear) begin
                cnt_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_dest_d  = out_dest_q;
        out_wr_d    = out_wr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = bus.in_instr;
            out_a_d     = rd_a;
            out_b_d     = rd_b;
            out_dest_d  = bus.in_dest;
            out_wr_d    = bus.in_wr;
        end else if (bus.out_ready || bus.flush) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_dest_q  <= '0;
            out_wr_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_dest_q  <= out_dest_d;
            out_wr_q    <= out_wr_d;
        end
    end
endmodule

// File: tb/tb_decode_stage_p.sv
// Scoreboard bench for decode_stage_p: directed scenarios then random traffic,
// checked against an array-based reference model.
module tb_decode_stage_p;
    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;
    localparam int CW = 2;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_p_if #(.DATA_W(DW), .RA_W(AW)) bus ();

    decode_stage_p #(.DATA_W(DW), .NREGS(NR), .RA_W(AW), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic          valid;
        logic [DW-1:0] instr;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          ua;
        logic          ub;
        logic [AW-1:0] d;
        logic          w;
        logic          wl;
        logic [AW-1:0] wd;
        logic [DW-1:0] wdat;
        logic          fl;
        logic          sbc;
        logic          ordy;
    } stim_t;

    typedef struct {
        logic [DW-1:0] instr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] dest;
        logic          wr;
    } exp_t;

    // Reference model state: value and pending-write count per register.
    logic [DW-1:0] m_rf [NR];
    int            m_cnt [NR];
    bit            m_valid;
    logic [AW-1:0] m_dest;
    bit            m_wr;
    exp_t          q [$];

    int n_chk = 0;
    int n_fail = 0;
    bit armed = 1'b0;
    bit exp_stall, exp_ready, exp_ovalid, exp_xfer;
    exp_t mon_e;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.valid = 0; s.instr = '0; s.a = '0; s.b = '0; s.ua = 0; s.ub = 0;
        s.d = '0; s.w = 0; s.wl = 0; s.wd = '0; s.wdat = '0;
        s.fl = 0; s.sbc = 0; s.ordy = 1;
        return s;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_rf[r] = '0;
            m_cnt[r] = 0;
        end
        m_valid = 0;
        m_dest = '0;
        m_wr = 0;
        q.delete();
    endtask

    task automatic drive_bus(input stim_t s);
        bus.in_valid = s.valid; bus.in_instr = s.instr;
        bus.in_src_a = s.a; bus.in_src_b = s.b;
        bus.in_use_a = s.ua; bus.in_use_b = s.ub;
        bus.in_dest = s.d; bus.in_wr = s.w;
        bus.wb_load = s.wl; bus.wb_dest = s.wd; bus.wb_data = s.wdat;
        bus.flush = s.fl; bus.sb_clear = s.sbc; bus.out_ready = s.ordy;
    endtask

    // Drive one cycle of inputs and advance the model to the state after the next edge.
    task automatic apply(input stim_t s);
        logic [DW-1:0] ra, rb;
        bit blk_a, blk_b, full, hz, acc;
        exp_t e;
        drive_bus(s);
        ra = (s.wl && s.wd == s.a) ? s.wdat : m_rf[s.a];
        rb = (s.wl && s.wd == s.b) ? s.wdat : m_rf[s.b];
        blk_a = s.ua && m_cnt[s.a] > 0 && !(s.wl && s.wd == s.a && m_cnt[s.a] == 1);
        blk_b = s.ub && m_cnt[s.b] > 0 && !(s.wl && s.wd == s.b && m_cnt[s.b] == 1);
        full = s.w && m_cnt[s.d] == CMAX;
        hz = s.valid && (blk_a || blk_b || full);
        exp_stall = hz;
        exp_ready = !hz && (!m_valid || s.ordy) && !s.fl;
        acc = s.valid && exp_ready;
        exp_ovalid = m_valid;
        exp_xfer = m_valid && s.ordy && !s.fl;
        if (s.fl && m_valid && q.size() > 0) q.delete(0);
        if (acc) begin
            e.instr = s.instr; e.a = ra; e.b = rb; e.dest = s.d; e.wr = s.w;
            q.push_back(e);
        end
        for (int r = 0; r < NR; r++) begin
            int c = m_cnt[r];
            if (acc && s.w && s.d == r) c++;
            if (s.wl && s.wd == r && c > 0) c--;
            if (s.fl && m_valid && m_wr && m_dest == r && c > 0) c--;
            m_cnt[r] = s.sbc ? 0 : c;
        end
        if (s.wl) m_rf[s.wd] = s.wdat;
        if (acc) begin
            m_valid = 1; m_dest = s.d; m_wr = s.w;
        end else if (s.ordy || s.fl) begin
            m_valid = 0;
        end
        armed = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        int busy [$];
        s.valid = $urandom_range(0, 9) < 7;
        s.instr = DW'($urandom);
        s.a = AW'($urandom_range(0, NR - 1));
        s.b = AW'($urandom_range(0, NR - 1));
        s.ua = 1'($urandom);
        s.ub = 1'($urandom);
        s.d = AW'($urandom_range(0, NR - 1));
        s.w = $urandom_range(0, 3) != 0;
        s.wl = 1'($urandom);
        s.wd = AW'($urandom_range(0, NR - 1));
        for (int r = 0; r < NR; r++) if (m_cnt[r] > 0) busy.push_back(r);
        if (busy.size() > 0 && $urandom_range(0, 9) < 8)
            s.wd = AW'(busy[$urandom_range(0, busy.size() - 1)]);
        s.wdat = DW'($urandom);
        s.fl = $urandom_range(0, 19) == 0;
        s.sbc = $urandom_range(0, 49) == 0;
        s.ordy = $urandom_range(0, 9) < 7;
        return s;
    endfunction

    always @(negedge clk) begin
        if (reset_n && armed) begin
            chk("stall_raw", bus.stall_raw, exp_stall);
            chk("in_ready", bus.in_ready, exp_ready);
            chk("out_valid", bus.out_valid, exp_ovalid);
            if (exp_xfer) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: transfer with no expected entry");
                end else begin
                    mon_e = q.pop_front();
                    chk("out_instr", bus.out_instr, mon_e.instr);
                    chk("out_a", bus.out_a, mon_e.a);
                    chk("out_b", bus.out_b, mon_e.b);
                    chk("out_dest", bus.out_dest, mon_e.dest);
                    chk("out_wr", bus.out_wr, mon_e.wr);
                end
            end
        end
    end

    initial begin
        stim_t s;
        model_reset();
        drive_bus(idle());
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_instr", bus.out_instr, 0);
        chk("rst_out_a", bus.out_a, 0);
        chk("rst_out_b", bus.out_b, 0);
        chk("rst_out_dest", bus.out_dest, 0);
        chk("rst_out_wr", bus.out_wr, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        reset_n = 1'b1;
        apply(idle()); tick();

        // Writeback then read through the output register.
        s = idle(); s.wl = 1; s.wd = 3; s.wdat = 16'h1234; apply(s); tick();
        s = idle(); s.valid = 1; s.instr = 16'h0001; s.a = 3; s.ua = 1; apply(s);
        #1 chk("t1_in_ready", bus.in_ready, 1); tick();
        s = idle(); s.ordy = 0; apply(s);
        #1 chk("t1_out_valid", bus.out_valid, 1); chk("t1_out_a", bus.out_a, 16'h1234); tick();
        apply(idle()); tick();

        // RAW stall released by same-cycle writeback bypass.
        s = idle(); s.valid = 1; s.instr = 16'h0002; s.d = 2; s.w = 1; apply(s); tick();
        s = idle(); s.valid = 1; s.instr = 16'h0003; s.a = 2; s.ua = 1; apply(s);
        #1 chk("t2_stall", bus.stall_raw, 1); chk("t2_not_ready", bus.in_ready, 0); tick();
        s.wl = 1; s.wd = 2; s.wdat = 16'hBEEF; apply(s);
        #1 chk("t2_bypass_nostall", bus.stall_raw, 0); chk("t2_ready", bus.in_ready, 1); tick();
        s = idle(); s.ordy = 0; apply(s);
        #1 chk("t2_out_a", bus.out_a, 16'hBEEF); chk("t2_out_instr", bus.out_instr, 16'h0003);
        tick();
        s = idle(); s.valid = 1; s.instr = 16'h0004; s.a = 2; s.ua = 1; apply(s);
        #1 chk("t2_cnt2_zero", bus.stall_raw, 0); tick();

        // Counter saturation on R5.
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.valid = 1; s.instr = DW'(16'h0050 + i); s.d = 5; s.w = 1;
            apply(s); tick();
        end
        s = idle(); s.valid = 1; s.instr = 16'h0053; s.d = 5; s.w = 1; apply(s);
        #1 chk("t3_full_stall", bus.stall_raw, 1); tick();
        s.wl = 1; s.wd = 5; s.wdat = 16'h5555; apply(s);
        #1 chk("t3_full_stall_wb", bus.stall_raw, 1); tick();
        s.wl = 0; apply(s);
        #1 chk("t3_release", bus.stall_raw, 0); chk("t3_ready", bus.in_ready, 1); tick();
        s = idle(); s.sbc = 1; apply(s); tick();

        // Back-pressure hold.
        s = idle(); s.valid = 1; s.instr = 16'h00AA; apply(s); tick();
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.valid = 1; s.instr = 16'h00BB; s.ordy = 0; apply(s);
            #1 chk("t4_hold_valid", bus.out_valid, 1); chk("t4_hold_instr", bus.out_instr, 16'h00AA);
            chk("t4_hold_not_ready", bus.in_ready, 0); tick();
        end
        s.ordy = 1; apply(s);
        #1 chk("t4_release_ready", bus.in_ready, 1); tick();
        s = idle(); s.ordy = 0; apply(s);
        #1 chk("t4_next_instr", bus.out_instr, 16'h00BB); tick();
        apply(idle()); tick();

        // Flush of a pending writer to R4.
        s = idle(); s.valid = 1; s.instr = 16'h0044; s.d = 4; s.w = 1; apply(s); tick();
        s = idle(); s.valid = 1; s.instr = 16'h0055; s.fl = 1; s.ordy = 0; apply(s);
        #1 chk("t5_flush_not_ready", bus.in_ready, 0); chk("t5_out_dest", bus.out_dest, 4); tick();
        s = idle(); s.ordy = 0; apply(s);
        #1 chk("t5_flushed", bus.out_valid, 0); tick();
        s = idle(); s.valid = 1; s.instr = 16'h0066; s.a = 4; s.ua = 1; apply(s);
        #1 chk("t5_cnt4_zero", bus.stall_raw, 0); tick();

        repeat (1500) begin
            apply(rand_stim());
            tick();
        end
        s = idle(); s.sbc = 1; apply(s); tick();
        apply(idle()); tick();

        // Asynchronous reset in the middle of a stall with cnt[1]=2.
        s = idle(); s.valid = 1; s.instr = 16'h0071; s.d = 1; s.w = 1; apply(s); tick();
        s.instr = 16'h0072; apply(s); tick();
        s = idle(); s.valid = 1; s.instr = 16'h0073; s.a = 1; s.ua = 1; s.ordy = 0; apply(s);
        #1 chk("t6_stall", bus.stall_raw, 1); chk("t6_valid", bus.out_valid, 1);
        #1 reset_n = 1'b0;
        armed = 0;
        #1 chk("t6_rst_valid", bus.out_valid, 0); chk("t6_rst_instr", bus.out_instr, 0);
        chk("t6_rst_a", bus.out_a, 0); chk("t6_rst_wr", bus.out_wr, 0);
        chk("t6_rst_cnt_cleared", bus.stall_raw, 0); chk("t6_rst_ready", bus.in_ready, 1);
        model_reset();
        tick();
        chk("t6_rst_hold", bus.out_valid, 0);
        reset_n = 1'b1;
        s.ordy = 1; apply(s);
        #1 chk("t6_after_nostall", bus.stall_raw, 0); tick();
        apply(idle()); tick();
        apply(idle()); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
- Parametrised decode stage: register file, per-register pending-write scoreboard, and a registered ID/EX output with valid/ready handshake.
- Sits between fetch and execute. Takes pre-extracted register indices plus the raw instruction word from the fetch stage.
- Takes writebacks from the WB stage and stalls fetch on RAW hazards.
- Also supports: configurable register count and width, writeback-to-read bypass, multiple outstanding writes per register, and flush.

Parameters:
- DATA_W, 16, register and instruction width
- NREGS, 8, number of architectural registers (power of two, at least 2)
- RA_W, 3, register index width, equal to log2(NREGS)
- CNT_W, 2, width of each scoreboard counter; allows up to 2^CNT_W-1 outstanding writes per register

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode accepts this cycle
- in_instr  in  DATA_W  raw instruction, passed through to the output
- in_src_a  in  RA_W  source A index
- in_src_b  in  RA_W  source B index
- in_use_a  in  1  source A is read
- in_use_b  in  1  source B is read
- in_dest  in  RA_W  destination index
- in_wr  in  1  instruction writes in_dest
- wb_load  in  1  writeback enable
- wb_dest  in  RA_W  writeback register
- wb_data  in  DATA_W  writeback value
- flush  in  1  squash the instruction in the output register
- sb_clear  in  1  zero every scoreboard counter
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  execute accepts
- out_instr  out  DATA_W  registered instruction
- out_a  out  DATA_W  registered source A value
- out_b  out  DATA_W  registered source B value
- out_dest  out  RA_W  registered destination
- out_wr  out  1  registered write flag
- stall_raw  out  1  hazard stall indicator (combinational)

Behaviour:

Reset (reset_n=0, asynchronous):
- All registers and all scoreboard counters go to 0.
- out_valid=0; out_instr, out_a, out_b, out_dest and out_wr go to 0.
- Holds for the whole reset assertion, including mid-handshake; any in-progress transfer is dropped.

Register file:
- Written on the clock edge when wb_load=1.
- Reads are combinational with bypass: if wb_load=1 and wb_dest equals the read index, the read returns wb_data in the same cycle.

Scoreboard:
- One CNT_W-bit counter per register, cnt[r].
- hazard = in_valid AND ((in_use_a AND cnt[in_src_a]!=0 AND NOT bypass_a) OR (in_use_b AND cnt[in_src_b]!=0 AND NOT bypass_b) OR (in_wr AND cnt[in_dest] at maximum)).
- bypass_x means wb_load=1, wb_dest equals the source index, and cnt[source]==1.
- stall_raw = hazard.

Handshake:
- in_ready = NOT hazard AND (NOT out_valid OR out_ready) AND NOT flush.
- Accept = in_valid AND in_ready. On accept the output register loads in_instr, both bypassed read values, in_dest and in_wr, and out_valid becomes 1.
- Else if out_ready=1, out_valid becomes 0.
- Else the output register holds (stable while out_valid=1 and out_ready=0).

Counter update, per register r, applied in this order:
- +1 if accept with in_wr=1 and in_dest=r.
- -1 if wb_load=1 and wb_dest=r and cnt[r]!=0.
- -1 if flush=1, out_valid=1, out_wr=1 and out_dest=r (squashed write).
- Increment and decrement in the same cycle net to 0.
- Counters never wrap: an increment at maximum is impossible because of the hazard term; a decrement at 0 is ignored.

Flush:
- flush=1 clears out_valid next cycle and blocks accept that cycle.
- sb_clear=1 zeroes all counters. It has priority over every increment and decrement that cycle.

Latency: 1 cycle from accept to out_valid.

Test Plan:
- Reset, then write R3=0x1234 via WB, then issue src_a=3 -> out_a=0x1234 one cycle after accept; out_valid=1.
- Issue instr with dest=R2, in_wr=1, then a dependent src_a=2 with no WB -> stall_raw=1 and in_ready=0. Then wb_load R2=0xBEEF -> accept in that same cycle with out_a=0xBEEF (bypass); cnt[2] returns to 0.
- CNT_W=2: three back-to-back writes to R5 with no WB -> cnt[5]=3; a fourth writer stalls until one wb_load to R5 arrives.
- Hold out_ready=0 with out_valid=1 for 4 cycles -> all outputs stable, in_ready=0; release -> the next instruction loads.
- flush while out holds dest=R4, in_wr=1 -> out_valid=0 next cycle, cnt[4] decremented, in_ready=0 during the flush cycle.
- Assert reset_n=0 asynchronously mid-stall with cnt[1]=2 -> out_valid and all counters go to 0 immediately, without a clock edge.
